// File: rtl/systolic_mm_engine.sv
// Output-stationary systolic matrix-multiply engine: C = A * B for a run-time K,
// with internal operand skewing, flush sequencing and row-serial result drain.
module systolic_mm_engine #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int AW   = 20,
    parameter int KW   = 8,
    localparam int IW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROWS*DW-1:0]   a_col,
    input  logic [COLS*DW-1:0]   b_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COLS*AW-1:0]   out_row,
    output logic [IW-1:0]        out_idx,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int FW = $clog2(ROWS + COLS) + 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);
    localparam int AC = (COLS > 1) ? COLS - 1 : 1;
    localparam int BR = (ROWS > 1) ? ROWS - 1 : 1;

    state_t               state_r, state_next_s;
    logic [KW-1:0]        k_len_r, beat_cnt_r;
    logic [FW-1:0]        flush_cnt_r;
    logic                 busy_r, in_ready_r, out_valid_r, done_r;
    logic [IW-1:0]        out_idx_r, rd_idx_s;
    logic [COLS*AW-1:0]   out_row_r, row_s;
    logic                 clr_s, en_s, accept_s, last_beat_s, last_row_s;

    logic signed [DW-1:0]   a_feed_s [ROWS];
    logic signed [DW-1:0]   b_feed_s [COLS];
    logic signed [DW-1:0]   a_skew_s [ROWS];
    logic signed [DW-1:0]   b_skew_s [COLS];
    logic signed [DW-1:0]   a_in_s   [ROWS][COLS];
    logic signed [DW-1:0]   b_in_s   [ROWS][COLS];
    logic signed [DW-1:0]   a_pass_r [ROWS][AC];
    logic signed [DW-1:0]   b_pass_r [BR][COLS];
    logic signed [2*DW-1:0] prod_s   [ROWS][COLS];
    logic signed [AW-1:0]   acc_r    [ROWS][COLS];

    assign busy      = busy_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_row   = out_row_r;
    assign out_idx   = out_idx_r;
    assign done      = done_r;

    // Control strobes shared by the datapath and the FSM
    always_comb begin
        clr_s       = (state_r == IDLE) && start;
        en_s        = (state_r == LOAD) || (state_r == FLUSH);
        accept_s    = in_valid && in_ready_r;
        last_beat_s = (({1'b0, beat_cnt_r} + {{KW{1'b0}}, 1'b1}) == {1'b0, k_len_r});
        last_row_s  = (out_idx_r == IW'(ROWS - 1));
    end

    // Operand feed: a non-accepted cycle injects zeros so bubbles add nothing
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            a_feed_s[i] = accept_s ? a_col[i*DW +: DW] : {DW{1'b0}};
        end
        for (int j = 0; j < COLS; j++) begin
            b_feed_s[j] = accept_s ? b_row[j*DW +: DW] : {DW{1'b0}};
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        if (i == 0) begin : g_direct
            assign a_skew_s[i] = a_feed_s[i];
        end else begin : g_chain
            logic signed [DW-1:0] chain_r [i];
            // Lane i of A is delayed by i stages before entering column 0
            always_ff @(posedge clk) begin
                if (!rstn || clr_s) begin
                    for (int k = 0; k < i; k++) chain_r[k] <= {DW{1'b0}};
                end else if (en_s) begin
                    chain_r[0] <= a_feed_s[i];
                    for (int k = 1; k < i; k++) chain_r[k] <= chain_r[k-1];
                end
            end
            assign a_skew_s[i] = chain_r[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        if (j == 0) begin : g_direct
            assign b_skew_s[j] = b_feed_s[j];
        end else begin : g_chain
            logic signed [DW-1:0] chain_r [j];
            // Lane j of B is delayed by j stages before entering row 0
            always_ff @(posedge clk) begin
                if (!rstn || clr_s) begin
                    for (int k = 0; k < j; k++) chain_r[k] <= {DW{1'b0}};
                end else if (en_s) begin
                    chain_r[0] <= b_feed_s[j];
                    for (int k = 1; k < j; k++) chain_r[k] <= chain_r[k-1];
                end
            end
            assign b_skew_s[j] = chain_r[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_in_s[i][j] = a_skew_s[i];
            end else begin : g_a_inner
                assign a_in_s[i][j] = a_pass_r[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in_s[i][j] = b_skew_s[j];
            end else begin : g_b_inner
                assign b_in_s[i][j] = b_pass_r[i-1][j];
            end
            assign prod_s[i][j] = a_in_s[i][j] * b_in_s[i][j];

            // MAC: wraps modulo 2^AW and is frozen outside LOAD/FLUSH
            always_ff @(posedge clk) begin
                if (!rstn || clr_s) acc_r[i][j] <= {AW{1'b0}};
                else if (en_s)      acc_r[i][j] <= acc_r[i][j] + AW'(prod_s[i][j]);
            end

            if (j < COLS - 1) begin : g_a_pass
                // Forward A to the right neighbour
                always_ff @(posedge clk) begin
                    if (!rstn || clr_s) a_pass_r[i][j] <= {DW{1'b0}};
                    else if (en_s)      a_pass_r[i][j] <= a_in_s[i][j];
                end
            end
            if (i < ROWS - 1) begin : g_b_pass
                // Forward B to the neighbour below
                always_ff @(posedge clk) begin
                    if (!rstn || clr_s) b_pass_r[i][j] <= {DW{1'b0}};
                    else if (en_s)      b_pass_r[i][j] <= b_in_s[i][j];
                end
            end
        end
    end

    // FSM next-state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = (k_len == {KW{1'b0}}) ? DRAIN : LOAD;
                else       state_next_s = IDLE;
            end
            LOAD: begin
                if (accept_s && last_beat_s) state_next_s = FLUSH;
                else                         state_next_s = LOAD;
            end
            FLUSH: begin
                if (flush_cnt_r == FLUSH_LAST) state_next_s = DRAIN;
                else                           state_next_s = FLUSH;
            end
            DRAIN: begin
                if (out_valid_r && out_ready && last_row_s) state_next_s = DONE;
                else                                        state_next_s = DRAIN;
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register and status flags registered from the next state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            busy_r     <= (state_next_s != IDLE);
            in_ready_r <= (state_next_s == LOAD);
            done_r     <= (state_next_s == DONE);
        end
    end

    // Job length latch, beat counter and flush timer
    always_ff @(posedge clk) begin
        if (!rstn) begin
            k_len_r     <= {KW{1'b0}};
            beat_cnt_r  <= {KW{1'b0}};
            flush_cnt_r <= {FW{1'b0}};
        end else begin
            if (clr_s) begin
                k_len_r    <= k_len;
                beat_cnt_r <= {KW{1'b0}};
            end else if (accept_s) begin
                beat_cnt_r <= beat_cnt_r + {{(KW-1){1'b0}}, 1'b1};
            end
            if (state_r == FLUSH) flush_cnt_r <= flush_cnt_r + {{(FW-1){1'b0}}, 1'b1};
            else                  flush_cnt_r <= {FW{1'b0}};
        end
    end

    // Row to present next: the current one, or its successor once accepted
    always_comb begin
        rd_idx_s = out_idx_r;
        if (out_valid_r && !last_row_s) rd_idx_s = out_idx_r + IW'(1);
        else                            rd_idx_s = out_idx_r;
        for (int j = 0; j < COLS; j++) row_s[j*AW +: AW] = acc_r[rd_idx_s][j];
    end

    // Result drain: first DRAIN cycle loads row 0, each handshake advances
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_r <= 1'b0;
            out_idx_r   <= {IW{1'b0}};
            out_row_r   <= {(COLS*AW){1'b0}};
        end else if (state_r == DRAIN && !out_valid_r) begin
            out_valid_r <= 1'b1;
            out_row_r   <= row_s;
        end else if (state_r == DRAIN && out_ready) begin
            if (last_row_s) begin
                out_valid_r <= 1'b0;
                out_idx_r   <= {IW{1'b0}};
                out_row_r   <= {(COLS*AW){1'b0}};
            end else begin
                out_idx_r   <= rd_idx_s;
                out_row_r   <= row_s;
            end
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Scoreboard bench for systolic_mm_engine: expected C rows are queued per job
// from a reference product and popped on every output handshake.
module tb_systolic_mm_engine;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DW     = 8;
    localparam int AW     = 20;
    localparam int KW     = 8;
    localparam int IW     = 2;
    localparam int BUDGET = 400;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               start = 1'b0;
    logic [KW-1:0]      k_len = '0;
    logic               busy;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [ROWS*DW-1:0] a_col = '0;
    logic [COLS*DW-1:0] b_row = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [COLS*AW-1:0] out_row;
    logic [IW-1:0]      out_idx;
    logic               done;

    always #5 clk = ~clk;

    systolic_mm_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .KW(KW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_idx(out_idx), .done(done)
    );

    typedef struct {
        int                 idx;
        logic [COLS*AW-1:0] row;
    } exp_t;

    exp_t exp_q[$];
    int   a_m [ROWS][64];
    int   b_m [64][COLS];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_expected(input int k);
        exp_t                 e;
        logic signed [AW-1:0] acc;
        for (int i = 0; i < ROWS; i++) begin
            e.idx = i;
            e.row = '0;
            for (int j = 0; j < COLS; j++) begin
                acc = '0;
                for (int kk = 0; kk < k; kk++) acc = acc + AW'(a_m[i][kk] * b_m[kk][j]);
                e.row[j*AW +: AW] = acc;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_random(input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < ROWS; i++) a_m[i][kk] = int'($urandom_range(0, 255)) - 128;
            for (int j = 0; j < COLS; j++) b_m[kk][j] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic drive_beat(input int beat, input bit real_beat);
        for (int i = 0; i < ROWS; i++)
            a_col[i*DW +: DW] = real_beat ? a_m[i][beat][DW-1:0] : DW'($urandom);
        for (int j = 0; j < COLS; j++)
            b_row[j*DW +: DW] = real_beat ? b_m[beat][j][DW-1:0] : DW'($urandom);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"},      busy,      1'b0);
        check({pfx, "_in_ready"},  in_ready,  1'b0);
        check({pfx, "_out_valid"}, out_valid, 1'b0);
        check({pfx, "_done"},      done,      1'b0);
        check({pfx, "_out_idx"},   out_idx,   '0);
        check({pfx, "_out_row"},   out_row,   '0);
    endtask

    // vmode 0: in_valid always high; 1: 1-0-0-1 pattern. poke pulses start in FLUSH.
    task automatic run_job(input int k, input int vmode, input int stall,
                           input int exp_lat, input bit poke);
        int                 cyc, beats, extra, done_cnt, tail, wait_cnt, first_cyc;
        bit                 poked, stalled, xfer, hs;
        logic [COLS*AW-1:0] held_row;
        logic [IW-1:0]      held_idx;
        exp_t               e;
        push_expected(k);
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; beats = 0; extra = 0; done_cnt = 0; tail = 0; wait_cnt = 0;
        first_cyc = -1; poked = 1'b0; stalled = 1'b0;
        held_row = '0; held_idx = '0;
        while (cyc < BUDGET && !(done_cnt > 0 && tail >= 2)) begin
            if (beats < k) in_valid = (vmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            else           in_valid = 1'b1;
            drive_beat(beats, (beats < k) && in_valid);
            if (poke && !poked && k > 0 && beats == k) begin
                start = 1'b1;
                k_len = KW'(5);
                poked = 1'b1;
            end
            out_ready = (wait_cnt >= stall);
            if (stalled && out_valid) begin
                check("hold_row", out_row, held_row);
                check("hold_idx", out_idx, held_idx);
            end
            stalled  = out_valid && !out_ready;
            held_row = out_row;
            held_idx = out_idx;
            xfer = in_valid && in_ready;
            hs   = out_valid && out_ready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("extra_row", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("row_idx", out_idx, e.idx);
                    check("row_data", out_row, e.row);
                end
                wait_cnt = 0;
            end else if (out_valid) begin
                wait_cnt++;
            end
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (xfer) begin
                if (beats < k) beats++;
                else           extra++;
            end
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (done)              done_cnt++;
            else if (done_cnt > 0) tail++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("timeout", cyc < BUDGET, 1'b1);
        check("beats_accepted", beats, k);
        check("extra_beats", extra, 0);
        check("done_once", done_cnt, 1);
        check("busy_after_done", busy, 1'b0);
        check("rows_left", exp_q.size(), 0);
        if (exp_lat > 0) check("first_valid_latency", first_cyc, exp_lat);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Identity A, B[k][j] = k*4+j
        for (int i = 0; i < ROWS; i++)
            for (int kk = 0; kk < 4; kk++) a_m[i][kk] = (i == kk) ? 1 : 0;
        for (int kk = 0; kk < 4; kk++)
            for (int j = 0; j < COLS; j++) b_m[kk][j] = kk * 4 + j;
        run_job(4, 0, 0, 12, 1'b0);

        // Signed outer product, K=1
        a_m[0][0] = -3; a_m[1][0] = 2; a_m[2][0] = -1; a_m[3][0] = 5;
        b_m[0][0] = 4;  b_m[0][1] = -7; b_m[0][2] = 1; b_m[0][3] = -128;
        run_job(1, 0, 0, 0, 1'b0);

        // Random operands with input bubbles and output backpressure
        fill_random(8);
        run_job(8, 1, 3, 0, 1'b0);

        // Accumulator wrap, then an empty job
        for (int kk = 0; kk < 40; kk++) begin
            for (int i = 0; i < ROWS; i++) a_m[i][kk] = -128;
            for (int j = 0; j < COLS; j++) b_m[kk][j] = -128;
        end
        run_job(40, 0, 0, 0, 1'b0);
        run_job(0, 0, 1, 0, 1'b0);

        // Reset after 3 of 8 beats
        fill_random(8);
        start = 1'b1;
        k_len = KW'(8);
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            drive_beat(b, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1;
        check_all_zero("abort");
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", done, 1'b0);

        // start pulsed during FLUSH must be ignored
        fill_random(3);
        run_job(3, 0, 1, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("start_ignored", busy, 1'b0);

        // Fresh job with no residue from earlier work
        fill_random(2);
        run_job(2, 0, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
